sinc3: RTL and testbench

//  Third-order CIC (sinc^3) decimation filter for a 1-bit PDM microphone stream.
//  - Runs entirely in the microphone-clock domain (mclk1, nominally 2.75 MHz).
//  - Converts PDM density into unsigned 8-bit PCM at mclk1/DEC (about 43 kHz for DEC=64).
//  - Flags each new sample with data_en. The consumer edge-detects data_en in its own domain.

---
 rtl/sinc3.sv | 103 ++++++++++
 tb/tb_sinc3.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sinc3.sv
// sinc3: third-order CIC decimator turning a 1-bit PDM stream into 8-bit
// unsigned PCM at mclk1/DEC. Single clock domain (mclk1), synchronous
// active-low reset. The output strobe data_en is one mclk1 cycle wide and
// coincides with the DATA update, so a consumer in another domain can simply
// edge-detect it.
//
// Handshake: there is no back-pressure. data_en is a pure valid strobe. DATA
// is stable from the edge that raises data_en until the next such edge.
//
// Pipeline: integrators run every cycle. The comb chain updates on the tick
// cycle, where cnt == DEC-1. The output register loads on the cycle after the
// tick. This gives a first strobe DEC+1 cycles after reset release and a
// strobe every DEC cycles after that.
//
// DEC must be a power of two in 8..256. The counter relies on natural
// wrap-around, and the output slice relies on DEC^3 being 2^(ACC_W-1).
module sinc3 #(
  parameter int DEC = 64
) (
  input  logic       mclk1,
  input  logic       reset,
  input  logic       mdata1,
  output logic [7:0] DATA,
  output logic       data_en
);

  localparam int CNT_W = $clog2(DEC);
  localparam int ACC_W = 3 * CNT_W + 1;
  localparam logic [ACC_W-1:0] SAT_LIM = ACC_W'(1) << (ACC_W - 1);

  logic [ACC_W-1:0] r_i1, r_i2, r_i3;
  logic [ACC_W-1:0] r_c1, r_c2, r_c3;
  logic [ACC_W-1:0] r_z1, r_z2, r_z3;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick_d;

  logic             w_tick;
  logic [7:0]       w_pcm;

  // The tick marks the last cycle of each decimation frame.
  assign w_tick = (r_cnt == CNT_W'(DEC - 1));

  // Full scale (DEC^3) does not fit the 8-bit slice, so it is forced to 0xFF.
  // Every other result takes bits [ACC_W-2 -: 8] and is truncated, not rounded.
  assign w_pcm = (r_c3 >= SAT_LIM) ? 8'hFF : 8'(r_c3 >> (ACC_W - 9));

  // Integrator cascade, modulo 2^ACC_W. Wrap-around cancels in the combs.
  always_ff @(posedge mclk1) begin
    if (!reset) begin
      r_i1 <= '0;
      r_i2 <= '0;
      r_i3 <= '0;
    end else begin
      r_i1 <= r_i1 + ACC_W'(mdata1);
      r_i2 <= r_i2 + r_i1;
      r_i3 <= r_i3 + r_i2;
    end
  end

  // Decimation counter, plus a one-cycle delayed tick that launches the output stage.
  always_ff @(posedge mclk1) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_tick_d <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_tick_d <= w_tick;
    end
  end

  // Pipelined comb chain. Each stage differences against its previous tick's input.
  always_ff @(posedge mclk1) begin
    if (!reset) begin
      r_c1 <= '0;
      r_c2 <= '0;
      r_c3 <= '0;
      r_z1 <= '0;
      r_z2 <= '0;
      r_z3 <= '0;
    end else if (w_tick) begin
      r_c1 <= r_i3 - r_z1;
      r_z1 <= r_i3;
      r_c2 <= r_c1 - r_z2;
      r_z2 <= r_c1;
      r_c3 <= r_c2 - r_z3;
      r_z3 <= r_c2;
    end
  end

  // Output register and strobe. DATA holds its value between strobes.
  always_ff @(posedge mclk1) begin
    if (!reset) begin
      DATA    <= 8'h00;
      data_en <= 1'b0;
    end else begin
      data_en <= r_tick_d;
      if (r_tick_d) begin
        DATA <= w_pcm;
      end
    end
  end

endmodule

// File: tb/tb_sinc3.sv
// tb_sinc3: directed bench for the sinc3 decimator (DEC=64). Outputs are
// sampled on the falling edge. The input bit for the next rising edge is
// driven right after each sample, from a 4-bit repeating pattern.
module tb_sinc3;

  logic       mclk1;
  logic       reset;
  logic       mdata1;
  logic [7:0] DATA;
  logic       data_en;

  sinc3 #(.DEC(64)) dut (
    .mclk1   (mclk1),
    .reset   (reset),
    .mdata1  (mdata1),
    .DATA    (DATA),
    .data_en (data_en)
  );

  // ---------------- clock / reset ----------------
  initial begin
    mclk1 = 1'b0;
    forever #5 mclk1 = ~mclk1;
  end

  int         checks;
  int         errors;
  logic [3:0] pat;      // bit k is the input for pattern phase k
  int         pat_idx;
  int         since;    // cycles since reset release or the last strobe
  logic       s_en;
  logic [7:0] s_data;
  logic [7:0] exp_q[$];

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: sample the outputs, then drive the next pattern bit.
  task automatic step();
    @(negedge mclk1);
    s_en   = data_en;
    s_data = DATA;
    since++;
    mdata1  = pat[pat_idx];
    pat_idx = (pat_idx + 1) % 4;
  endtask

  // Hold reset low for n edges, check the cleared outputs, then release.
  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      step();
      chk("rst_data", s_data, 8'h00);
      chk("rst_en", s_en, 1'b0);
    end
    reset = 1'b1;
    since = 0;
  endtask

  // Wait (bounded) for the next strobe and check its distance from the previous one.
  task automatic wait_pulse(input int exp_gap, output logic [7:0] d);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_en && n < 200);
    chk("pulse_seen", s_en, 1'b1);
    chk("pulse_gap", since, exp_gap);
    d     = s_data;
    since = 0;
  endtask

  // Collect n strobes after a release. From strobe settle onward, each value
  // must match the scoreboard entry.
  task automatic run_pulses(input int n, input int settle, input logic [7:0] val);
    logic [7:0] d;
    logic [7:0] e;
    for (int k = settle; k <= n; k++) exp_q.push_back(val);
    for (int k = 1; k <= n; k++) begin
      wait_pulse((k == 1) ? 65 : 64, d);
      if (k >= settle) begin
        e = exp_q.pop_front();
        chk("pulse_data", d, e);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic [7:0] d;
    logic [7:0] prev;
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    mdata1  = 1'b0;
    pat_idx = 0;
    since   = 0;

    // Reset for 4 cycles, then all-zero input: timing and DATA=0 on every strobe.
    pat = 4'b0000;
    apply_reset(4);
    run_pulses(8, 1, 8'h00);

    // All-ones input saturates to 0xFF once settled.
    pat = 4'b1111;
    apply_reset(2);
    run_pulses(8, 6, 8'hFF);

    // Reset mid-frame while saturated, then 50% density settles to 0x80.
    repeat (20) step();
    pat = 4'b0101;
    apply_reset(1);
    run_pulses(8, 6, 8'h80);

    // 75% density gives 0xC0.
    pat = 4'b0111;
    apply_reset(2);
    run_pulses(7, 6, 8'hC0);

    // 25% density gives 0x40, then a phase-continuous step up to 75%.
    pat = 4'b0001;
    apply_reset(2);
    run_pulses(6, 6, 8'h40);
    pat  = 4'b0111;
    prev = 8'h40;
    for (int k = 1; k <= 7; k++) begin
      wait_pulse(64, d);
      chk("step_mono", (d >= prev), 1'b1);
      if (k == 1) chk("step_first", d, 8'h40);
      if (k >= 6) chk("step_final", d, 8'hC0);
      prev = d;
    end

    // Reset that lands on the edge that would emit a strobe: no sample leaks out.
    repeat (63) step();
    pat = 4'b0101;
    apply_reset(1);
    run_pulses(6, 6, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
